// File: rtl/block_aligner.sv
// Rx block synchronizer: hunts for the 2-bit sync-header boundary in the raw
// deserializer words by bit-slipping, declares block lock, and delivers the
// aligned header and 62-bit scrambled payload to the descrambler.
// Bit 0 of every vector is the first bit received.
// The slip arithmetic assumes WORD_WIDTH is a power of two.
// DATA_WIDTH must equal WORD_WIDTH-2.
module block_aligner #(
  parameter int WORD_WIDTH = 64,
  parameter int DATA_WIDTH = 62,
  parameter int LOCK_CNT   = 64,
  parameter int BER_WIN    = 64,
  parameter int BER_MAX    = 16
) (
  input  logic                          clk_390p625M,
  input  logic                          rst,
  input  logic [0:WORD_WIDTH-1]         raw_data_in,
  output logic [0:DATA_WIDTH-1]         scrambled_data_out,
  output logic [1:0]                    sync_hdr_out,
  output logic                          data_valid_out,
  output logic                          block_lock,
  output logic [$clog2(WORD_WIDTH)-1:0] slip_offset
);

  localparam int OFF_W = $clog2(WORD_WIDTH);
  localparam int SH_W  = $clog2(LOCK_CNT) + 1;
  localparam int WIN_W = $clog2(BER_WIN) + 1;
  localparam int BAD_W = $clog2(BER_MAX) + 1;

  localparam logic [SH_W-1:0]  SH_LAST = SH_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0] WIN_END = WIN_W'(BER_WIN);
  localparam logic [BAD_W-1:0] BAD_END = BAD_W'(BER_MAX);

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  // Two-word history; the block window may straddle both words.
  logic [0:WORD_WIDTH-1]   cur_q;
  logic [0:WORD_WIDTH-1]   prev_q;
  logic [0:2*WORD_WIDTH-1] cat;
  logic [0:WORD_WIDTH-1]   win;
  logic [OFF_W:0]          win_base;
  logic                    hdr_ok;

  state_t                  state_q;
  logic [OFF_W-1:0]        off_q;
  logic [SH_W-1:0]         sh_cnt_q;
  logic [WIN_W-1:0]        win_cnt_q;
  logic [WIN_W-1:0]        win_cnt_d;
  logic [BAD_W-1:0]        bad_cnt_q;
  logic [BAD_W-1:0]        bad_cnt_d;
  // Counts pipeline fill after reset; headers are judged only once prev/cur
  // both hold words received after reset, so reset zeros are never hunted on.
  logic [1:0]              fill_q;
  logic [0:DATA_WIDTH-1]   pay_q;
  logic [1:0]              hdr_q;
  logic                    lock_q;

  assign cat      = {prev_q, cur_q};
  assign win_base = {1'b0, off_q};
  assign win      = cat[win_base +: WORD_WIDTH];
  // Valid headers are 01 (data) and 10 (control): the two bits differ.
  assign hdr_ok   = win[0] ^ win[1];

  // Next values of the BER window counters for the header being judged.
  always_comb begin
    win_cnt_d = win_cnt_q + WIN_W'(1);
    bad_cnt_d = bad_cnt_q + {{(BAD_W-1){1'b0}}, ~hdr_ok};
  end

  // Datapath pipeline, registered outputs and lock FSM (one header per cycle).
  always_ff @(posedge clk_390p625M) begin
    if (rst) begin
      cur_q     <= '0;
      prev_q    <= '0;
      pay_q     <= '0;
      hdr_q     <= '0;
      fill_q    <= '0;
      state_q   <= ST_HUNT;
      off_q     <= '0;
      sh_cnt_q  <= '0;
      win_cnt_q <= '0;
      bad_cnt_q <= '0;
      lock_q    <= 1'b0;
    end else begin
      cur_q  <= raw_data_in;
      prev_q <= cur_q;
      pay_q  <= win[2:WORD_WIDTH-1];
      hdr_q  <= win[0:1];
      if (fill_q != 2'd2) begin
        fill_q <= fill_q + 2'd1;
      end
      case (state_q)
        ST_HUNT: begin
          if (fill_q == 2'd2) begin
            if (hdr_ok) begin
              if (sh_cnt_q == SH_LAST) begin
                state_q   <= ST_LOCKED;
                lock_q    <= 1'b1;
                sh_cnt_q  <= '0;
                win_cnt_q <= '0;
                bad_cnt_q <= '0;
              end else begin
                sh_cnt_q <= sh_cnt_q + SH_W'(1);
              end
            end else begin
              sh_cnt_q <= '0;
              off_q    <= off_q + OFF_W'(1);
              state_q  <= ST_SLIP_WAIT;
            end
          end
        end
        // The window has just moved; skip one header before judging again.
        ST_SLIP_WAIT: begin
          state_q <= ST_HUNT;
        end
        ST_LOCKED: begin
          // Loss of lock takes priority over the window rollover.
          if (bad_cnt_d == BAD_END) begin
            lock_q    <= 1'b0;
            off_q     <= off_q + OFF_W'(1);
            sh_cnt_q  <= '0;
            win_cnt_q <= '0;
            bad_cnt_q <= '0;
            state_q   <= ST_SLIP_WAIT;
          end else if (win_cnt_d == WIN_END) begin
            win_cnt_q <= '0;
            bad_cnt_q <= '0;
          end else begin
            win_cnt_q <= win_cnt_d;
            bad_cnt_q <= bad_cnt_d;
          end
        end
        default: begin
          state_q <= ST_HUNT;
        end
      endcase
    end
  end

  assign scrambled_data_out = pay_q;
  assign sync_hdr_out       = hdr_q;
  assign block_lock         = lock_q;
  assign data_valid_out     = lock_q & (state_q != ST_SLIP_WAIT);
  assign slip_offset        = off_q;

endmodule

// File: tb/tb_block_aligner.sv
// Bench for block_aligner: a bit-stream generator feeds shifted block streams,
// a reference model predicts every output each cycle, and directed sequences
// and a vector table cover lock timing, BER loss of lock, slip wrap and reset.
module tb_block_aligner;

  logic        clk;
  logic        rst;
  logic [0:63] raw_data_in;
  logic [0:61] scrambled_data_out;
  logic [1:0]  sync_hdr_out;
  logic        data_valid_out;
  logic        block_lock;
  logic [5:0]  slip_offset;

  int n_chk = 0;
  int n_err = 0;

  block_aligner dut (
    .clk_390p625M       (clk),
    .rst                (rst),
    .raw_data_in        (raw_data_in),
    .scrambled_data_out (scrambled_data_out),
    .sync_hdr_out       (sync_hdr_out),
    .data_valid_out     (data_valid_out),
    .block_lock         (block_lock),
    .slip_offset        (slip_offset)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Stream view: the header of the block under test starts 'm_off' bits into
  // the older of the two most recent words.
  logic [0:63] m_prev, m_cur;
  int          m_off, m_fill, m_good_run, m_win, m_bad;
  bit          m_locked, m_wait;
  logic [0:61] e_pay;
  logic [1:0]  e_hdr;

  function automatic logic [0:63] window_of(input logic [0:63] p, input logic [0:63] c, input int off);
    logic [0:63] w;
    for (int i = 0; i < 64; i++) begin
      int j;
      j = off + i;
      w[i] = (j < 64) ? p[j] : c[j - 64];
    end
    return w;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_cur = '0; m_off = 0; m_fill = 0;
    m_good_run = 0; m_win = 0; m_bad = 0;
    m_locked = 0; m_wait = 0; e_pay = '0; e_hdr = '0;
  endtask

  task automatic model_step(input logic [0:63] w);
    logic [0:63] blk;
    bit good;
    blk   = window_of(m_prev, m_cur, m_off);
    e_pay = blk[2:63];
    e_hdr = {blk[0], blk[1]};
    good  = (e_hdr == 2'b01) || (e_hdr == 2'b10);
    if (m_wait) begin
      m_wait = 0;
    end else if (m_locked) begin
      m_win++;
      if (!good) m_bad++;
      if (m_bad == 16) begin
        m_locked = 0; m_wait = 1; m_off = (m_off + 1) % 64;
        m_win = 0; m_bad = 0; m_good_run = 0;
      end else if (m_win == 64) begin
        m_win = 0; m_bad = 0;
      end
    end else if (m_fill >= 2) begin
      if (good) begin
        m_good_run++;
        if (m_good_run == 64) begin
          m_locked = 1; m_good_run = 0; m_win = 0; m_bad = 0;
        end
      end else begin
        m_good_run = 0; m_wait = 1; m_off = (m_off + 1) % 64;
      end
    end
    if (m_fill < 2) m_fill++;
    m_prev = m_cur;
    m_cur  = w;
  endtask

  // ---------------- drivers ----------------
  bit bq[$];

  task automatic send_word(input logic [0:63] w);
    raw_data_in = w;
    @(posedge clk);
    #1;
    model_step(w);
    chk("payload", 64'(scrambled_data_out), 64'(e_pay));
    chk("sync_hdr", 64'(sync_hdr_out), 64'(e_hdr));
    chk("data_valid", 64'(data_valid_out), 64'(m_locked && !m_wait));
    chk("block_lock", 64'(block_lock), 64'(m_locked));
    chk("slip_offset", 64'(slip_offset), 64'(m_off));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    raw_data_in = {$urandom(), $urandom()};
    @(posedge clk);
    #1;
    model_reset();
    bq.delete();
    chk("rst_payload", 64'(scrambled_data_out), 64'd0);
    chk("rst_hdr", 64'(sync_hdr_out), 64'd0);
    chk("rst_valid", 64'(data_valid_out), 64'd0);
    chk("rst_lock", 64'(block_lock), 64'd0);
    chk("rst_offset", 64'(slip_offset), 64'd0);
    rst = 1'b0;
  endtask

  task automatic push_block(input logic [1:0] h, input logic [0:61] p);
    bq.push_back(h[1]);
    bq.push_back(h[0]);
    for (int i = 0; i < 62; i++) bq.push_back(p[i]);
  endtask

  task automatic send_queued();
    logic [0:63] w;
    while (bq.size() >= 64) begin
      for (int i = 0; i < 64; i++) w[i] = bq.pop_front();
      send_word(w);
    end
  endtask

  // One block with a random valid (bad=0) or invalid (bad=1) header.
  task automatic send_block(input bit bad);
    logic [63:0] r;
    logic [1:0]  h;
    r = {$urandom(), $urandom()};
    if (bad) h = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
    else     h = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    push_block(h, r[61:0]);
    send_queued();
  endtask

  // Position the stream so the next block sent is the first of a BER window.
  task automatic align_window();
    int n;
    n = 0;
    while (m_win != 62 && n < 200) begin
      send_block(0);
      n++;
    end
    chk("align_timeout", 64'(n < 200), 64'd1);
  endtask

  task automatic send_until_lock(input string name, input int budget);
    int n;
    n = 0;
    while (!block_lock && n < budget) begin
      send_block(0);
      n++;
    end
    chk(name, 64'(block_lock), 64'd1);
  endtask

  // Aligned counter stream after reset: exact lock point and 2-clock latency.
  task automatic run_aligned_counter();
    logic [0:61] p;
    do_reset();
    for (int j = 0; j < 68; j++) begin
      p = 62'(j);
      push_block(2'b01, p);
      send_queued();
      if (j == 64) chk("lock_before_64th", 64'(block_lock), 64'd0);
      if (j == 65) chk("lock_at_64th", 64'(block_lock), 64'd1);
    end
    chk("cnt_payload", 64'(scrambled_data_out), 64'd65);
    chk("cnt_hdr", 64'(sync_hdr_out), 64'd1);
    chk("cnt_valid", 64'(data_valid_out), 64'd1);
    chk("cnt_offset", 64'(slip_offset), 64'd0);
  endtask

  typedef struct {
    int shift;
    int exp_off;
    int budget;
  } vec_t;

  vec_t vecs[5];

  initial begin
    rst = 1'b0;
    raw_data_in = '0;
    model_reset();
    vecs[0] = '{shift: 0,  exp_off: 0,  budget: 200};
    vecs[1] = '{shift: 1,  exp_off: 1,  budget: 400};
    vecs[2] = '{shift: 40, exp_off: 40, budget: 2000};
    vecs[3] = '{shift: 17, exp_off: 17, budget: 2000};
    vecs[4] = '{shift: 62, exp_off: 62, budget: 3000};

    // Aligned stream, lock after exactly 64 headers.
    run_aligned_counter();

    // BER: 15 bad in a window keeps lock, 16 drops it.
    align_window();
    for (int i = 0; i < 15; i++) send_block(1);
    for (int i = 0; i < 60; i++) send_block(0);
    chk("ber15_lock", 64'(block_lock), 64'd1);
    align_window();
    for (int i = 0; i < 16; i++) send_block(1);
    send_block(0);
    chk("ber16_still_lock", 64'(block_lock), 64'd1);
    send_block(0);
    chk("ber16_unlock", 64'(block_lock), 64'd0);
    chk("ber16_offset", 64'(slip_offset), 64'd1);

    // Shifted streams: hunt to the expected offset.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int b = 0; b < vecs[v].shift; b++) bq.push_back(1'($urandom_range(0, 1)));
      send_until_lock("vec_lock", vecs[v].budget);
      chk("vec_offset", 64'(slip_offset), 64'(vecs[v].exp_off));
      for (int i = 0; i < 8; i++) send_block(0);
    end

    // Loss of lock at offset 62 -> 63, stream now aligned at 0: wrap and relock.
    align_window();
    for (int i = 0; i < 16; i++) send_block(1);
    send_block(0);
    send_block(0);
    chk("wrap_unlock", 64'(block_lock), 64'd0);
    chk("wrap_offset63", 64'(slip_offset), 64'd63);
    bq.delete();
    send_until_lock("wrap_relock", 600);
    chk("wrap_offset0", 64'(slip_offset), 64'd0);

    // HUNT: bad header after 63 good ones restarts the count.
    do_reset();
    for (int i = 0; i < 63; i++) send_block(0);
    send_block(1);
    send_block(0);
    chk("hunt63_offset_hold", 64'(slip_offset), 64'd0);
    send_block(0);
    chk("hunt63_no_lock", 64'(block_lock), 64'd0);
    chk("hunt63_slip", 64'(slip_offset), 64'd1);
    for (int i = 0; i < 64; i++) send_block(0);
    chk("hunt63_still_hunting", 64'(block_lock), 64'd0);
    send_until_lock("hunt63_relock", 3000);
    chk("hunt63_offset", 64'(slip_offset), 64'd0);

    // Reset while locked, then relock as on a fresh link.
    for (int i = 0; i < 5; i++) send_block(0);
    run_aligned_counter();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
